dec4to16: RTL and testbench
===========================

# dec4to16

Registered 4-to-16 one-hot decoder with enable. On each clock edge the 4-bit select `a` is decoded into a 16-bit one-hot word on `s` when `en` is high, and `s` is forced to all-inactive when `en` is low. It sits between control logic and per-line selects (register-file write strobes, chip selects, demux steering), where a glitch-free registered select is required.

## Interface
Parameters:
- `ACTIVE_LOW`, default 0: output polarity. 0 means the selected line is 1 and the others are 0. 1 means the selected line is 0 and the others are 1.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `a` input, 4 bits: select index, 0 to 15.
- `en` input, 1 bit: decode enable, active-high.
- `s` output, 16 bits: registered decoded word; bit `s[k]` corresponds to index k.
- `valid` output, 1 bit: registered copy of `en`. It is 1 when `s` holds a decoded one-hot word.

## Operation
- Decode function, for `ACTIVE_LOW`=0:
  - With `en`=1: `s_next[k]` = 1 if k == `a`, else 0. Exactly one bit is set.
  - With `en`=0: `s_next` = 16'h0000, regardless of `a`.
- For `ACTIVE_LOW`=1: `s_next` is the bitwise inverse of the above. Disabled output is 16'hFFFF; enabled output has a single 0.
- `valid_next` = `en`.
- Decoding is full-range. All 16 codes of `a` are legal, and there is no out-of-range case.
- Bits of `a` that are X/Z have no defined output. The bench drives only known values.
- No internal state beyond the `s` and `valid` registers. There is no FSM, and no counter or wrap behaviour.
- The internal structure is free, for example two 2-to-4 predecoders ANDed into 16 lines. The only hard requirement is the registered output is exactly one-hot or all-zero, in active-high terms.

## Timing
- Latency is 1 cycle. The values of `a` and `en` sampled at edge N appear on `s` and `valid` after edge N and hold until edge N+1.
- The outputs come directly from flops, with no combinational path from inputs to `s` or `valid`.
- Reset:
  - With `rst`=1 at an edge, `s` becomes the disabled value after that edge: 16'h0000, or 16'hFFFF when `ACTIVE_LOW`=1. `valid` becomes 0.
  - `rst` has priority over `en`.
- Reset mid-operation: the enabled output is cleared at the first edge with `rst`=1. Decoding resumes at the first edge with `rst`=0, using `a` and `en` sampled at that edge.
- Simultaneous change of `a` and `en` at one edge: both are sampled together, so no intermediate select value appears on `s`.
- Toggling `en`:
  - An `en` 1→0 transition produces the disabled value one cycle later.
  - An `en` 0→1 transition produces the decoded value of the `a` sampled with it.
- Before the first reset, the outputs are undefined. The bench applies `rst` for at least 1 cycle at start.

## Test plan
- Reset: `rst`=1 for 2 cycles with `en`=1, `a`=5 → `s`=16'h0000, `valid`=0 throughout. After release, the next edge gives `s`=16'h0020, `valid`=1.
- Disabled: `en`=0 and sweep `a` from 0 to 15 → `s`=16'h0000, `valid`=0 on every cycle.
- Full sweep: `en`=1 and `a`=i for i=0..15, one value per cycle → one cycle later `s`=1<<i (16'h0001 … 16'h8000), `valid`=1, and the popcount of `s` is 1 each cycle.
- Enable drop: with `a`=15 and `en`=1, then `en`=0 while `a` is unchanged → `s` goes from 16'h8000 to 16'h0000 one cycle after the drop, and `valid` goes from 1 to 0.
- Mid-operation reset: during the sweep, assert `rst` at `a`=9 → the next `s`=16'h0000. After release with `a`=10, the next `s`=16'h0400.
- Polarity: with `ACTIVE_LOW`=1, `en`=1, `a`=3 → `s`=16'hFFF7. With `en`=0 → `s`=16'hFFFF. Reset gives 16'hFFFF.

Source files
------------

// File: rtl/dec4to16.sv
// dec4to16 - registered 4-to-16 one-hot decoder with enable.
//
// The 4-bit select is decoded into a 16-bit one-hot word. The result is
// registered, so downstream strobes and chip selects never see
// decode glitches.
//
// Parameters:
//   ACTIVE_LOW - 0: the selected line is 1 and the others are 0.
//                1: the selected line is 0 and the others are 1.
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - synchronous active-high reset; takes priority over en
//   a     - select index, 0..15 (all codes are legal)
//   en    - decode enable; when low, s is forced to the idle value
//   s     - registered decoded word; s[k] corresponds to index k
//   valid - registered copy of en; high when s holds a decoded word
module dec4to16 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  a,
  input  logic        en,
  output logic [15:0] s,
  output logic        valid
);

  // Value of s when nothing is selected: during reset or while disabled.
  localparam logic [15:0] IDLE_WORD = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

  logic [3:0]  lo_sel;   // one-hot predecode of a[1:0]
  logic [3:0]  hi_sel;   // one-hot predecode of a[3:2], gated by en
  logic [15:0] hot;      // active-high one-hot word, or zero when disabled
  logic [15:0] s_next;
  logic [15:0] s_reg;
  logic        valid_reg;

  // Two 2-to-4 predecoders. The enable is folded into the high predecoder,
  // so a disabled decode gives all-zero lines without a separate mask stage.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_predec
      assign lo_sel[gi] = (a[1:0] == gi[1:0]);
      assign hi_sel[gi] = en && (a[3:2] == gi[1:0]);
    end

    // Line k is active when the high pair selects k/4 and the low pair
    // selects k%4. At most one line can satisfy both.
    for (gi = 0; gi < 16; gi++) begin : g_line
      assign hot[gi] = hi_sel[gi / 4] & lo_sel[gi % 4];
    end
  endgenerate

  // Polarity is applied before the register, so s comes straight from flops.
  assign s_next = ACTIVE_LOW ? ~hot : hot;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg     <= IDLE_WORD;
      valid_reg <= 1'b0;
    end else begin
      s_reg     <= s_next;
      valid_reg <= en;
    end
  end

  assign s     = s_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_dec4to16.sv
// Testbench for dec4to16. An active-high and an active-low instance share
// the same stimulus. Directed steps drive the inputs after a rising edge,
// and both instances are checked 1 ns after the following rising edge.
module tb_dec4to16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a;
  logic        en;
  logic [15:0] s_hi;
  logic [15:0] s_lo;
  logic        valid_hi;
  logic        valid_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec4to16 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .en    (en),
    .s     (s_hi),
    .valid (valid_hi)
  );

  dec4to16 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .en    (en),
    .s     (s_lo),
    .valid (valid_lo)
  );

  // Advance one clock edge and settle, so outputs are sampled after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] observed,
                     input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] exp_word;

    // Reset held for two edges while en=1, a=5.
    rst = 1'b1; en = 1'b1; a = 4'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_s",       s_hi,             16'h0000);
      chk("reset_valid",   {15'd0, valid_hi}, 16'h0000);
      chk("reset_s_low",   s_lo,             16'hFFFF);
      chk("reset_valid_l", {15'd0, valid_lo}, 16'h0000);
    end
    rst = 1'b0;
    step();
    chk("post_reset_s",     s_hi,             16'h0020);
    chk("post_reset_valid", {15'd0, valid_hi}, 16'h0001);

    // Disabled sweep: output stays idle for every select.
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      step();
      $display("disabled a=%0d s=%h s_low=%h valid=%b", i, s_hi, s_lo, valid_hi);
      chk("dis_s",     s_hi,             16'h0000);
      chk("dis_s_low", s_lo,             16'hFFFF);
      chk("dis_valid", {15'd0, valid_hi}, 16'h0000);
    end

    // Full enabled sweep, one select per cycle.
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      exp_word = 16'h0001 << i;
      step();
      $display("sweep a=%0d s=%h s_low=%h valid=%b", i, s_hi, s_lo, valid_hi);
      chk("sweep_s",     s_hi,                   exp_word);
      chk("sweep_s_low", s_lo,                   ~exp_word);
      chk("sweep_valid", {15'd0, valid_hi},       16'h0001);
      chk("sweep_pop",   16'($countones(s_hi)),  16'h0001);
    end

    // Enable drop with a held at 15.
    a = 4'd15; en = 1'b1;
    step();
    chk("drop_before_s",     s_hi,             16'h8000);
    chk("drop_before_valid", {15'd0, valid_hi}, 16'h0001);
    en = 1'b0;
    step();
    chk("drop_after_s",      s_hi,             16'h0000);
    chk("drop_after_valid",  {15'd0, valid_hi}, 16'h0000);

    // Mid-operation reset at a=9, resume at a=10.
    en = 1'b1; a = 4'd8;
    step();
    chk("mid_pre_s", s_hi, 16'h0100);
    a = 4'd9; rst = 1'b1;
    step();
    chk("mid_rst_s",     s_hi,             16'h0000);
    chk("mid_rst_valid", {15'd0, valid_hi}, 16'h0000);
    chk("mid_rst_s_low", s_lo,             16'hFFFF);
    rst = 1'b0; a = 4'd10;
    step();
    chk("mid_resume_s",     s_hi,             16'h0400);
    chk("mid_resume_valid", {15'd0, valid_hi}, 16'h0001);

    // Polarity checks on the active-low instance.
    a = 4'd3; en = 1'b1;
    step();
    chk("pol_en_low",  s_lo, 16'hFFF7);
    chk("pol_en_high", s_hi, 16'h0008);
    en = 1'b0;
    step();
    chk("pol_dis_low", s_lo, 16'hFFFF);
    rst = 1'b1; en = 1'b1;
    step();
    chk("pol_rst_low", s_lo, 16'hFFFF);
    chk("pol_rst_valid", {15'd0, valid_lo}, 16'h0000);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
